// File: rtl/inst_fetch.sv
// Instruction fetch front end: fetch PC, credit-limited memory requests,
// prefetch FIFO and redirect flush with in-flight response dropping.
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_req_addr_o,
  input  logic        mem_rsp_valid_i,
  input  logic [31:0] mem_rsp_data_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t state, state_next;

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [31:0]   redirect_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] drop_cnt_next;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credits_used;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [31:0]   fifo_inst [FIFO_DEPTH];
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic          req_fire;
  logic          rsp_fire;
  logic          push;
  logic          pop;
  logic [CW-1:0] req_inc;
  logic [CW-1:0] rsp_dec;
  logic [CW-1:0] push_inc;
  logic [CW-1:0] pop_dec;

  assign redirect_pc  = {redirect_pc_i[31:2], 2'b00};
  assign credits_used = {1'b0, fifo_count} + {1'b0, outstanding};

  // Outstanding requests reserve a FIFO slot, so responses never overflow.
  assign mem_req_valid_o =
    !reset && (credits_used < (CW+1)'(FIFO_DEPTH));
  assign mem_req_addr_o = fetch_pc;

  assign req_fire = mem_req_valid_o && mem_req_ready_i;
  assign rsp_fire = mem_rsp_valid_i;

  assign inst_valid_o = fifo_count != '0;
  assign pop  = inst_valid_o && inst_ready_i;
  assign push = rsp_fire && (drop_cnt == '0) && !redirect_i;

  assign inst_o    = inst_valid_o ? fifo_inst[rd_ptr] : NOP;
  assign inst_pc_o = inst_valid_o ? fifo_pc[rd_ptr] : '0;

  assign req_inc  = {{(CW-1){1'b0}}, req_fire};
  assign rsp_dec  = {{(CW-1){1'b0}}, rsp_fire};
  assign push_inc = {{(CW-1){1'b0}}, push};
  assign pop_dec  = {{(CW-1){1'b0}}, pop};

  always_comb begin
    outstanding_next = outstanding + req_inc - rsp_dec;
  end

  always_comb begin
    drop_cnt_next = drop_cnt;
    if (redirect_i) begin
      drop_cnt_next = outstanding_next;
    end else if (rsp_fire && drop_cnt != '0) begin
      drop_cnt_next = drop_cnt - CW'(1);
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      RUN: begin
        if (redirect_i && outstanding_next != '0) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        if (drop_cnt_next == '0) begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      state       <= state_next;
      outstanding <= outstanding_next;
      drop_cnt    <= drop_cnt_next;
      if (redirect_i) begin
        fetch_pc   <= redirect_pc;
        rsp_pc     <= redirect_pc;
        fifo_count <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (push) begin
          rsp_pc <= rsp_pc + 32'd4;
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        fifo_count <= fifo_count + push_inc - pop_dec;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_inst[wr_ptr] <= mem_rsp_data_i;
      fifo_pc[wr_ptr]   <= rsp_pc;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a fixed-latency in-order memory model.
// Instruction words are the fetch address XOR KEY.
module tb_inst_fetch;

  localparam logic [31:0] KEY = 32'h5A00_00A5;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock;
  logic        reset;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [31:0] mem_req_addr_o;
  logic        mem_rsp_valid_i;
  logic [31:0] mem_rsp_data_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;

  int checks = 0;
  int errors = 0;
  int lat = 1;

  logic [7:0]  mv;
  logic [31:0] ma [8];

  logic [31:0] got_pc[$];
  logic [31:0] got_inst[$];
  int          got_cyc[$];

  inst_fetch dut (
    .clock           (clock),
    .reset           (reset),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_data_i  (mem_rsp_data_i),
    .inst_valid_o    (inst_valid_o),
    .inst_ready_i    (inst_ready_i),
    .inst_o          (inst_o),
    .inst_pc_o       (inst_pc_o)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Memory: response exactly lat cycles after the accepting cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) mv <= '0;
    else mv <= {mv[6:0], mem_req_valid_o && mem_req_ready_i};
  end

  always_ff @(posedge clock) begin
    ma[0] <= mem_req_addr_o;
    for (int i = 1; i < 8; i++) ma[i] <= ma[i-1];
  end

  assign mem_rsp_valid_i = mv[lat-1];
  assign mem_rsp_data_i  = ma[lat-1] ^ KEY;

  task automatic do_reset();
    reset = 1'b1;
    redirect_i = 1'b0;
    redirect_pc_i = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
  endtask

  task automatic collect(input int n, input int budget);
    got_pc.delete();
    got_inst.delete();
    got_cyc.delete();
    for (int c = 0; c < budget && got_pc.size() < n; c++) begin
      if (inst_valid_o && inst_ready_i) begin
        got_pc.push_back(inst_pc_o);
        got_inst.push_back(inst_o);
        got_cyc.push_back(c);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    redirect_i = 1'b0;
    redirect_pc_i = '0;
    mem_req_ready_i = 1'b1;
    inst_ready_i = 1'b1;
    @(negedge clock);
    #1;
    checks++;
    if (mem_req_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_req_valid got %b want 0", mem_req_valid_o);
    end
    checks++;
    if (mem_req_addr_o !== 32'h0) begin
      errors++; $display("FAIL reset_addr got %h want 0", mem_req_addr_o);
    end
    checks++;
    if (inst_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_inst_valid got %b want 0", inst_valid_o);
    end
    checks++;
    if (inst_o !== NOP) begin
      errors++; $display("FAIL reset_inst got %h want %h", inst_o, NOP);
    end
    checks++;
    if (inst_pc_o !== 32'h0) begin
      errors++; $display("FAIL reset_inst_pc got %h want 0", inst_pc_o);
    end
  endtask

  task automatic test_stream();
    lat = 1;
    mem_req_ready_i = 1'b1;
    inst_ready_i = 1'b1;
    do_reset();
    checks++;
    if (mem_req_valid_o !== 1'b1) begin
      errors++; $display("FAIL first_req_valid got %b want 1", mem_req_valid_o);
    end
    collect(4, 20);
    checks++;
    if (got_pc.size() != 4) begin
      errors++; $display("FAIL stream_count got %0d want 4", got_pc.size());
    end
    if (got_cyc.size() > 0) begin
      checks++;
      if (got_cyc[0] != 2) begin
        errors++; $display("FAIL first_latency got %0d want 2", got_cyc[0]);
      end
    end
    for (int i = 0; i < got_pc.size(); i++) begin
      checks++;
      if (got_pc[i] !== 32'(4 * i) || got_inst[i] !== (32'(4 * i) ^ KEY)) begin
        errors++;
        $display("FAIL stream_%0d got pc %h inst %h want pc %h",
                 i, got_pc[i], got_inst[i], 32'(4 * i));
      end
    end
  endtask

  task automatic test_backpressure();
    int fires;
    lat = 1;
    mem_req_ready_i = 1'b1;
    inst_ready_i = 1'b0;
    do_reset();
    fires = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_req_valid_o && mem_req_ready_i) fires++;
      @(negedge clock);
    end
    checks++;
    if (fires != 4) begin
      errors++; $display("FAIL stall_fires got %0d want 4", fires);
    end
    checks++;
    if (mem_req_valid_o !== 1'b0) begin
      errors++; $display("FAIL stall_req_valid got %b want 0", mem_req_valid_o);
    end
    checks++;
    if (mem_req_addr_o !== 32'h10) begin
      errors++; $display("FAIL stall_addr got %h want 10", mem_req_addr_o);
    end
    inst_ready_i = 1'b1;
    collect(8, 40);
    checks++;
    if (got_pc.size() != 8) begin
      errors++; $display("FAIL resume_count got %0d want 8", got_pc.size());
    end
    for (int i = 0; i < got_pc.size(); i++) begin
      checks++;
      if (got_pc[i] !== 32'(4 * i) || got_inst[i] !== (32'(4 * i) ^ KEY)) begin
        errors++;
        $display("FAIL resume_%0d got pc %h inst %h want pc %h",
                 i, got_pc[i], got_inst[i], 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect_drop();
    lat = 5;
    mem_req_ready_i = 1'b1;
    inst_ready_i = 1'b1;
    do_reset();
    repeat (3) @(negedge clock);
    mem_req_ready_i = 1'b0;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h100;
    @(negedge clock);
    redirect_i = 1'b0;
    mem_req_ready_i = 1'b1;
    checks++;
    if (dut.drop_cnt !== 3'd3) begin
      errors++; $display("FAIL redir_drop_cnt got %0d want 3", dut.drop_cnt);
    end
    checks++;
    if (mem_req_addr_o !== 32'h100) begin
      errors++; $display("FAIL redir_addr got %h want 100", mem_req_addr_o);
    end
    collect(2, 40);
    checks++;
    if (got_pc.size() != 2) begin
      errors++; $display("FAIL redir_count got %0d want 2", got_pc.size());
    end
    for (int i = 0; i < got_pc.size(); i++) begin
      checks++;
      if (got_pc[i] !== 32'(256 + 4 * i) ||
          got_inst[i] !== (32'(256 + 4 * i) ^ KEY)) begin
        errors++;
        $display("FAIL redir_%0d got pc %h inst %h want pc %h",
                 i, got_pc[i], got_inst[i], 32'(256 + 4 * i));
      end
    end
  endtask

  task automatic test_back_to_back();
    lat = 2;
    mem_req_ready_i = 1'b1;
    inst_ready_i = 1'b1;
    do_reset();
    repeat (3) @(negedge clock);
    checks++;
    if (dut.outstanding !== 3'd2 || mem_rsp_valid_i !== 1'b1 ||
        mem_req_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_setup got outs %0d rsp %b req %b want 2 1 1",
               dut.outstanding, mem_rsp_valid_i, mem_req_valid_o);
    end
    redirect_i = 1'b1;
    redirect_pc_i = 32'h300;
    @(negedge clock);
    redirect_i = 1'b0;
    checks++;
    if (dut.drop_cnt !== 3'd2) begin
      errors++; $display("FAIL b2b_drop_cnt got %0d want 2", dut.drop_cnt);
    end
    collect(3, 40);
    checks++;
    if (got_pc.size() != 3) begin
      errors++; $display("FAIL b2b_count got %0d want 3", got_pc.size());
    end
    for (int i = 0; i < got_pc.size(); i++) begin
      checks++;
      if (got_pc[i] !== 32'(768 + 4 * i) ||
          got_inst[i] !== (32'(768 + 4 * i) ^ KEY)) begin
        errors++;
        $display("FAIL b2b_%0d got pc %h inst %h want pc %h",
                 i, got_pc[i], got_inst[i], 32'(768 + 4 * i));
      end
    end
  endtask

  task automatic test_align_wrap();
    lat = 1;
    mem_req_ready_i = 1'b0;
    inst_ready_i = 1'b1;
    do_reset();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h203;
    @(negedge clock);
    checks++;
    if (mem_req_addr_o !== 32'h200 || dut.drop_cnt !== 3'd0) begin
      errors++;
      $display("FAIL align got addr %h drop %0d want 200 0",
               mem_req_addr_o, dut.drop_cnt);
    end
    redirect_pc_i = 32'hFFFF_FFFE;
    @(negedge clock);
    redirect_i = 1'b0;
    checks++;
    if (mem_req_addr_o !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL top_addr got %h want fffffffc", mem_req_addr_o);
    end
    mem_req_ready_i = 1'b1;
    @(negedge clock);
    checks++;
    if (mem_req_addr_o !== 32'h0) begin
      errors++; $display("FAIL wrap_addr got %h want 0", mem_req_addr_o);
    end
    collect(2, 20);
    checks++;
    if (got_pc.size() != 2) begin
      errors++; $display("FAIL wrap_count got %0d want 2", got_pc.size());
    end
    if (got_pc.size() == 2) begin
      checks++;
      if (got_pc[0] !== 32'hFFFF_FFFC || got_pc[1] !== 32'h0 ||
          got_inst[1] !== KEY) begin
        errors++;
        $display("FAIL wrap_pcs got %h %h inst %h want fffffffc 0 %h",
                 got_pc[0], got_pc[1], got_inst[1], KEY);
      end
    end
  endtask

  task automatic test_reset_in_flush();
    lat = 5;
    mem_req_ready_i = 1'b1;
    inst_ready_i = 1'b1;
    do_reset();
    repeat (3) @(negedge clock);
    mem_req_ready_i = 1'b0;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h100;
    @(negedge clock);
    redirect_i = 1'b0;
    mem_req_ready_i = 1'b1;
    checks++;
    if (dut.drop_cnt !== 3'd3 || mem_req_addr_o !== 32'h100) begin
      errors++;
      $display("FAIL flush_setup got drop %0d addr %h want 3 100",
               dut.drop_cnt, mem_req_addr_o);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (mem_req_valid_o !== 1'b0 || mem_req_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL async_req got valid %b addr %h want 0 0",
               mem_req_valid_o, mem_req_addr_o);
    end
    checks++;
    if (inst_valid_o !== 1'b0 || inst_o !== NOP || inst_pc_o !== 32'h0) begin
      errors++;
      $display("FAIL async_inst got %b %h %h want 0 %h 0",
               inst_valid_o, inst_o, inst_pc_o, NOP);
    end
    checks++;
    if (dut.drop_cnt !== 3'd0 || dut.outstanding !== 3'd0) begin
      errors++;
      $display("FAIL async_state got drop %0d outs %0d want 0 0",
               dut.drop_cnt, dut.outstanding);
    end
    @(negedge clock);
    lat = 1;
    reset = 1'b0;
    #1;
    collect(2, 20);
    checks++;
    if (got_pc.size() != 2) begin
      errors++; $display("FAIL restart_count got %0d want 2", got_pc.size());
    end
    if (got_pc.size() == 2) begin
      checks++;
      if (got_pc[0] !== 32'h0 || got_pc[1] !== 32'h4 ||
          got_inst[0] !== KEY) begin
        errors++;
        $display("FAIL restart_pcs got %h %h inst %h want 0 4 %h",
                 got_pc[0], got_pc[1], got_inst[0], KEY);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    redirect_i = 1'b0;
    redirect_pc_i = '0;
    mem_req_ready_i = 1'b0;
    inst_ready_i = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_back_to_back();
    test_align_wrap();
    test_reset_in_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
